// File: rtl/regfile_wb_sched.sv
// regfile_wb_sched: two-source write-back buffer scheduler for the register file write port,
// draining oldest-first and flagging RAW hazards against pending results.
module regfile_wb_sched #(
    parameter int NSRC = 2,
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            s0_valid,
    output logic            s0_ready,
    input  logic [4:0]      s0_rd,
    input  logic [XLEN-1:0] s0_data,
    input  logic            s1_valid,
    output logic            s1_ready,
    input  logic [4:0]      s1_rd,
    input  logic [XLEN-1:0] s1_data,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic            hazard_stall,
    output logic            RegWrite,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] WriteData,
    output logic            busy
);
    logic [NSRC-1:0] full, grant, cap, hit;
    logic [4:0]      rd0, rd1;
    logic [XLEN-1:0] data0, data1;
    logic            s1_older;

    assign grant[0] = full[0] && !(full[1] && s1_older);
    assign grant[1] = full[1] && !(full[0] && !s1_older);
    assign s0_ready = !full[0] || grant[0];
    assign s1_ready = !full[1] || grant[1];
    assign cap[0]   = s0_valid && s0_ready && s0_rd != 5'd0;
    assign cap[1]   = s1_valid && s1_ready && s1_rd != 5'd0;
    assign hit[0]   = full[0] && ((rd0 == rs1 && rs1 != 5'd0) || (rd0 == rs2 && rs2 != 5'd0));
    assign hit[1]   = full[1] && ((rd1 == rs1 && rs1 != 5'd0) || (rd1 == rs2 && rs2 != 5'd0));

    assign hazard_stall = |hit;
    assign busy         = |full;
    assign RegWrite     = |grant;
    assign rd           = grant[1] ? rd1 : grant[0] ? rd0 : 5'd0;
    assign WriteData    = grant[1] ? data1 : grant[0] ? data0 : '0;

    // A buffer left behind when the other drains becomes the older one, keeping acceptance order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full     <= '0;
            s1_older <= 1'b0;
        end else begin
            full[0]  <= cap[0] || (full[0] && !grant[0]);
            full[1]  <= cap[1] || (full[1] && !grant[1]);
            s1_older <= (cap[0] && cap[1])               ? 1'b0 :
                        (cap[1] && (!full[0] || grant[0])) ? 1'b1 :
                        (cap[0] && (!full[1] || grant[1])) ? 1'b0 :
                        grant[0]                           ? 1'b1 :
                        grant[1]                           ? 1'b0 : s1_older;
        end
    end

    always_ff @(posedge clk) begin
        if (cap[0]) begin
            rd0   <= s0_rd;
            data0 <= s0_data;
        end
        if (cap[1]) begin
            rd1   <= s1_rd;
            data1 <= s1_data;
        end
    end
endmodule

// File: tb/tb_regfile_wb_sched.sv
// tb_regfile_wb_sched: scoreboard bench; accepted results are queued in acceptance order
// (source 0 first on ties) and every register-file write must match the queue head.
module tb_regfile_wb_sched;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        s0_valid, s0_ready, s1_valid, s1_ready;
    logic [4:0]  s0_rd, s1_rd, rs1, rs2, rd;
    logic [31:0] s0_data, s1_data, WriteData;
    logic        hazard_stall, RegWrite, busy;
    int          checks = 0;
    int          errors = 0;
    logic [36:0] q[$];
    logic [36:0] exp_w;

    regfile_wb_sched #(.NSRC(2), .XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_rd(s0_rd), .s0_data(s0_data),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_rd(s1_rd), .s1_data(s1_data),
        .rs1(rs1), .rs2(rs2), .hazard_stall(hazard_stall),
        .RegWrite(RegWrite), .rd(rd), .WriteData(WriteData), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && RegWrite) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write rd=%0d data=%h, no pending result expected", rd, WriteData);
            end else begin
                exp_w = q.pop_front();
                if ({rd, WriteData} !== exp_w) begin
                    errors++;
                    $display("FAIL write_order got rd=%0d data=%h expected rd=%0d data=%h",
                             rd, WriteData, exp_w[36:32], exp_w[31:0]);
                end
            end
        end
    end

    task automatic step();
        if (s0_valid && s0_ready && s0_rd != 5'd0) q.push_back({s0_rd, s0_data});
        if (s1_valid && s1_ready && s1_rd != 5'd0) q.push_back({s1_rd, s1_data});
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        s0_valid = 1'b0;
        s1_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        idle();
        while (busy && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL drain_timeout busy=%b expected 0", busy);
        end
    endtask

    task automatic test_reset();
        checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite got %b expected 0", RegWrite); end
        checks++; if (rd !== 5'd0) begin errors++; $display("FAIL reset_rd got %0d expected 0", rd); end
        checks++; if (WriteData !== 32'd0) begin errors++; $display("FAIL reset_wdata got %h expected 0", WriteData); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
        checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL reset_hazard got %b expected 0", hazard_stall); end
        checks++; if ({s0_ready, s1_ready} !== 2'b11) begin errors++; $display("FAIL reset_ready got %b expected 11", {s0_ready, s1_ready}); end
    endtask

    task automatic test_single();
        s0_valid = 1'b1; s0_rd = 5'd5; s0_data = 32'hDEADBEEF;
        step();
        idle();
        checks++; if (RegWrite !== 1'b1) begin errors++; $display("FAIL single_regwrite got %b expected 1", RegWrite); end
        checks++; if (rd !== 5'd5) begin errors++; $display("FAIL single_rd got %0d expected 5", rd); end
        checks++; if (WriteData !== 32'hDEADBEEF) begin errors++; $display("FAIL single_wdata got %h expected deadbeef", WriteData); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b expected 1", busy); end
        step();
        checks++; if ({busy, RegWrite} !== 2'b00) begin errors++; $display("FAIL single_done busy/regwrite got %b expected 00", {busy, RegWrite}); end
    endtask

    task automatic test_simultaneous();
        s0_valid = 1'b1; s0_rd = 5'd3; s0_data = 32'h11;
        s1_valid = 1'b1; s1_rd = 5'd3; s1_data = 32'h22;
        step();
        idle();
        checks++; if (s1_ready !== 1'b0) begin errors++; $display("FAIL simul_s1_ready got %b expected 0", s1_ready); end
        checks++; if ({rd, WriteData} !== {5'd3, 32'h11}) begin errors++; $display("FAIL simul_first got rd=%0d data=%h expected rd=3 data=11", rd, WriteData); end
        step();
        checks++; if ({rd, WriteData} !== {5'd3, 32'h22}) begin errors++; $display("FAIL simul_second got rd=%0d data=%h expected rd=3 data=22", rd, WriteData); end
        checks++; if (s1_ready !== 1'b1) begin errors++; $display("FAIL simul_s1_ready_after got %b expected 1", s1_ready); end
        drain();
    endtask

    task automatic test_age();
        s0_valid = 1'b1; s0_rd = 5'd4; s0_data = 32'h1;
        step();
        s0_valid = 1'b0;
        s1_valid = 1'b1; s1_rd = 5'd7; s1_data = 32'hA;
        step();
        checks++; if (rd !== 5'd7) begin errors++; $display("FAIL age_first got rd=%0d expected 7", rd); end
        s1_valid = 1'b0;
        s0_valid = 1'b1; s0_rd = 5'd8; s0_data = 32'hB;
        step();
        idle();
        checks++; if (rd !== 5'd8) begin errors++; $display("FAIL age_second got rd=%0d expected 8", rd); end
        drain();
    endtask

    task automatic test_back_to_back();
        s0_valid = 1'b1; s0_rd = 5'd10; s0_data = 32'h100;
        s1_valid = 1'b1; s1_rd = 5'd11; s1_data = 32'h200;
        step();
        s1_valid = 1'b0;
        s0_rd = 5'd12; s0_data = 32'h300;
        checks++; if (s0_ready !== 1'b1) begin errors++; $display("FAIL b2b_refill_ready got %b expected 1", s0_ready); end
        step();
        idle();
        checks++; if (rd !== 5'd11) begin errors++; $display("FAIL b2b_older_s1 got rd=%0d expected 11", rd); end
        step();
        checks++; if (rd !== 5'd12) begin errors++; $display("FAIL b2b_refilled got rd=%0d expected 12", rd); end
        drain();
    endtask

    task automatic test_discard();
        rs1 = 5'd0;
        s1_valid = 1'b1; s1_rd = 5'd0; s1_data = 32'hFFFF;
        checks++; if (s1_ready !== 1'b1) begin errors++; $display("FAIL x0_ready got %b expected 1", s1_ready); end
        step();
        idle();
        checks++; if ({RegWrite, busy, hazard_stall} !== 3'b000) begin errors++; $display("FAIL x0_discard regwrite/busy/hazard got %b expected 000", {RegWrite, busy, hazard_stall}); end
    endtask

    task automatic test_hazard();
        rs1 = 5'd0; rs2 = 5'd9;
        s0_valid = 1'b1; s0_rd = 5'd2; s0_data = 32'h5;
        s1_valid = 1'b1; s1_rd = 5'd9; s1_data = 32'h99;
        checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL hazard_pre got %b expected 0", hazard_stall); end
        step();
        idle();
        checks++; if (hazard_stall !== 1'b1) begin errors++; $display("FAIL hazard_pending got %b expected 1", hazard_stall); end
        step();
        checks++; if ({hazard_stall, rd} !== {1'b1, 5'd9}) begin errors++; $display("FAIL hazard_writing got stall=%b rd=%0d expected stall=1 rd=9", hazard_stall, rd); end
        step();
        checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL hazard_cleared got %b expected 0", hazard_stall); end
        rs2 = 5'd0;
    endtask

    task automatic test_stream();
        int writes = 0;
        for (int i = 0; i < 12; i++) begin
            s0_valid = 1'b1; s0_rd = 5'($urandom_range(1, 31)); s0_data = $urandom;
            s1_valid = 1'b1; s1_rd = 5'($urandom_range(1, 31)); s1_data = $urandom;
            step();
            if (RegWrite) writes++;
        end
        checks++; if (writes != 12) begin errors++; $display("FAIL stream_throughput got %0d writes expected 12", writes); end
        drain();
    endtask

    task automatic test_reset_mid();
        s0_valid = 1'b1; s0_rd = 5'd13; s0_data = 32'hAA;
        s1_valid = 1'b1; s1_rd = 5'd14; s1_data = 32'hBB;
        step();
        idle();
        #2;
        rst_n = 1'b0;
        q.delete();
        #1;
        checks++; if ({RegWrite, busy, hazard_stall} !== 3'b000) begin errors++; $display("FAIL midrst_outputs got %b expected 000", {RegWrite, busy, hazard_stall}); end
        checks++; if ({rd, WriteData} !== 37'd0) begin errors++; $display("FAIL midrst_rd_wdata got rd=%0d data=%h expected 0", rd, WriteData); end
        checks++; if ({s0_ready, s1_ready} !== 2'b11) begin errors++; $display("FAIL midrst_ready got %b expected 11", {s0_ready, s1_ready}); end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if ({RegWrite, busy} !== 2'b00) begin errors++; $display("FAIL midrst_no_write got regwrite/busy=%b expected 00", {RegWrite, busy}); end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        s0_valid = 1'b0; s0_rd = '0; s0_data = '0;
        s1_valid = 1'b0; s1_rd = '0; s1_data = '0;
        rs1 = '0; rs2 = '0;
        #1;
        test_reset();
        #11;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_single();
        test_simultaneous();
        test_age();
        test_back_to_back();
        test_discard();
        test_hazard();
        test_stream();
        test_reset_mid();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
